// File: rtl/ir_key_ctrl.sv
// Turns NEC IR frames into press / hold / release key events; hold ends on a timeout.
// Outputs registered, one clk after the frame strobe or timer expiry; no backpressure (input is a strobe).
module ir_key_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 6000000,
  parameter bit          ADDR_CHECK  = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_frame,
  input  logic             i_frame_vld,
  output logic [7:0]       o_addr,
  output logic [7:0]       o_cmd,
  output logic             o_key_press,
  output logic             o_key_release,
  output logic             o_key_held,
  output logic             o_frame_err,
  output logic [CNT_W-1:0] o_press_cnt
);

  localparam int unsigned   TW   = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [7:0]       addr_q, addr_d, cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d, rel_q, rel_d;
  logic             err_q, err_d, held_q, held_d;

  logic [7:0] f_addr, f_addr_n, f_cmd, f_cmd_n;
  logic       cmd_ok, addr_ok, good, same_key, expire;

  assign f_addr   = i_frame[31:24];
  assign f_addr_n = i_frame[23:16];
  assign f_cmd    = i_frame[15:8];
  assign f_cmd_n  = i_frame[7:0];

  assign cmd_ok   = (f_cmd ^ f_cmd_n) == 8'hFF;
  assign addr_ok  = (f_addr ^ f_addr_n) == 8'hFF;
  // Extended-address remotes use the complement byte as extra address bits.
  assign good     = i_frame_vld && cmd_ok && (addr_ok || !ADDR_CHECK);
  assign same_key = (f_addr == addr_q) && (f_cmd == cmd_q);
  assign expire   = (state_q == HELD) && (timer_q == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      cmd_q   <= '0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      err_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      err_q   <= err_d;
      held_q  <= held_d;
    end
  end

  // A good frame takes priority over expiry; a bad frame never touches the timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (good) state_d = HELD;
      end
      HELD: begin
        if (good) begin
          timer_d = '0;
        end else if (expire) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    err_d   = i_frame_vld && !good;
    held_d  = (state_d == HELD);
    if (good && ((state_q == IDLE) || !same_key)) begin
      press_d = 1'b1;
      addr_d  = f_addr;
      cmd_d   = f_cmd;
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (state_q == HELD) begin
      rel_d = good ? !same_key : expire;
    end
  end

  assign o_addr        = addr_q;
  assign o_cmd         = cmd_q;
  assign o_key_press   = press_q;
  assign o_key_release = rel_q;
  assign o_key_held    = held_q;
  assign o_frame_err   = err_q;
  assign o_press_cnt   = cnt_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Scoreboard bench for ir_key_ctrl: expected key events are queued as frames are driven
// and matched against the events the DUT emits (TIMEOUT_CYC = 100).
module tb_ir_key_ctrl;

  localparam int unsigned TO = 100;
  localparam logic [31:0] F1   = 32'h00FF_18E7;
  localparam logic [31:0] F2   = 32'h00FF_5AA5;
  localparam logic [31:0] BAD1 = 32'h00FF_1818;
  localparam logic [31:0] BAD2 = 32'h01FF_18E7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_frame = '0;
  logic        i_frame_vld = 1'b0;

  logic [7:0] o_addr, o_cmd, x_addr, x_cmd;
  logic       o_key_press, o_key_release, o_key_held, o_frame_err;
  logic       x_press, x_release, x_held, x_err;
  logic [7:0] o_press_cnt, x_cnt;

  ir_key_ctrl #(.TIMEOUT_CYC(TO), .ADDR_CHECK(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_frame(i_frame), .i_frame_vld(i_frame_vld),
    .o_addr(o_addr), .o_cmd(o_cmd), .o_key_press(o_key_press),
    .o_key_release(o_key_release), .o_key_held(o_key_held),
    .o_frame_err(o_frame_err), .o_press_cnt(o_press_cnt)
  );

  ir_key_ctrl #(.TIMEOUT_CYC(TO), .ADDR_CHECK(1'b0), .CNT_W(8)) dut_x (
    .clk(clk), .rst_n(rst_n), .i_frame(i_frame), .i_frame_vld(i_frame_vld),
    .o_addr(x_addr), .o_cmd(x_cmd), .o_key_press(x_press),
    .o_key_release(x_release), .o_key_held(x_held),
    .o_frame_err(x_err), .o_press_cnt(x_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned cyc;
    logic        press;
    logic        rel;
    logic        err;
    logic        held;
    logic [7:0]  addr;
    logic [7:0]  cmd;
    logic [7:0]  cnt;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int unsigned cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle carrying a pulse becomes one observed event.
  always @(negedge clk) begin
    ev_t o;
    if (rst_n && (o_key_press || o_key_release || o_frame_err)) begin
      o.cyc   = cyc;
      o.press = o_key_press;
      o.rel   = o_key_release;
      o.err   = o_frame_err;
      o.held  = o_key_held;
      o.addr  = o_addr;
      o.cmd   = o_cmd;
      o.cnt   = o_press_cnt;
      obs_q.push_back(o);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one strobe; c is the cycle stamp, so the response carries stamp c+1.
  task automatic send(input logic [31:0] f, output int unsigned c);
    c           = cyc;
    i_frame     = f;
    i_frame_vld = 1'b1;
    @(posedge clk);
    #1;
    i_frame_vld = 1'b0;
  endtask

  task automatic expect_ev(input int unsigned c, input logic p, input logic r, input logic e,
                           input logic h, input logic [7:0] a, input logic [7:0] m,
                           input logic [7:0] n);
    ev_t x;
    x.cyc = c; x.press = p; x.rel = r; x.err = e; x.held = h;
    x.addr = a; x.cmd = m; x.cnt = n;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    i_frame_vld = 1'b0;
    rst_n = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(2);
    vectors++;
    if ({o_addr, o_cmd, o_key_press, o_key_release, o_key_held, o_frame_err, o_press_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got addr=%h cmd=%h p=%b r=%b h=%b e=%b cnt=%h want all zero",
               o_addr, o_cmd, o_key_press, o_key_release, o_key_held, o_frame_err, o_press_cnt);
    end
    do_reset();
  endtask

  task automatic test_press();
    int unsigned c;
    ev_t e, o;
    do_reset();
    send(F1, c);
    expect_ev(c + 1, 1, 0, 0, 1, 8'h00, 8'h18, 8'd1);
    expect_ev(c + 1 + TO, 0, 1, 0, 0, 8'h00, 8'h18, 8'd1);
    wait_cyc(TO + 10);
    vectors++;
    if (o_key_held !== 1'b0 || o_cmd !== 8'h18) begin
      miscompares++;
      $display("FAIL press_after_release: got held=%b cmd=%h want held=0 cmd=18", o_key_held, o_cmd);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL press_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL press_event: got %h want %h", o, e); end
    end
  endtask

  task automatic test_hold();
    int unsigned c;
    ev_t e, o;
    do_reset();
    send(F1, c);
    expect_ev(c + 1, 1, 0, 0, 1, 8'h00, 8'h18, 8'd1);
    for (int k = 1; k < 5; k++) begin
      wait_cyc(59);
      send(F1, c);
    end
    expect_ev(c + 1 + TO, 0, 1, 0, 0, 8'h00, 8'h18, 8'd1);
    wait_cyc(TO - 1);
    vectors++;
    if (o_key_held !== 1'b1 || o_press_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL hold_before_timeout: got held=%b cnt=%0d want held=1 cnt=1", o_key_held, o_press_cnt);
    end
    wait_cyc(5);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL hold_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL hold_event: got %h want %h", o, e); end
    end
  endtask

  task automatic test_change();
    int unsigned c;
    int lows;
    ev_t e, o;
    do_reset();
    send(F1, c);
    expect_ev(c + 1, 1, 0, 0, 1, 8'h00, 8'h18, 8'd1);
    wait_cyc(29);
    send(F2, c);
    expect_ev(c + 1, 1, 1, 0, 1, 8'h00, 8'h5A, 8'd2);
    expect_ev(c + 1 + TO, 0, 1, 0, 0, 8'h00, 8'h5A, 8'd2);
    lows = 0;
    repeat (TO - 1) begin
      @(posedge clk); #1;
      if (!o_key_held) lows++;
    end
    vectors++;
    if (lows != 0) begin
      miscompares++;
      $display("FAIL change_held_gap: got %0d low cycles want 0", lows);
    end
    wait_cyc(5);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL change_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL change_event: got %h want %h", o, e); end
    end
  endtask

  task automatic test_bad();
    int unsigned c, c3;
    ev_t e, o;
    do_reset();
    send(BAD1, c);
    expect_ev(c + 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'd0);
    send(BAD2, c);
    expect_ev(c + 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'd0);
    vectors++;
    if ({x_press, x_err, x_addr, x_cmd, x_cnt} !== {1'b1, 1'b0, 8'h01, 8'h18, 8'd1}) begin
      miscompares++;
      $display("FAIL ext_addr_accept: got p=%b e=%b addr=%h cmd=%h cnt=%0d want p=1 e=0 addr=01 cmd=18 cnt=1",
               x_press, x_err, x_addr, x_cmd, x_cnt);
    end
    // A bad frame while held must not reload the hold timer.
    send(F1, c3);
    expect_ev(c3 + 1, 1, 0, 0, 1, 8'h00, 8'h18, 8'd1);
    wait_cyc(49);
    send(BAD1, c);
    expect_ev(c + 1, 0, 0, 1, 1, 8'h00, 8'h18, 8'd1);
    expect_ev(c3 + 1 + TO, 0, 1, 0, 0, 8'h00, 8'h18, 8'd1);
    wait_cyc(60);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL bad_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL bad_event: got %h want %h", o, e); end
    end
  endtask

  task automatic test_expiry();
    int unsigned c;
    ev_t e, o;
    do_reset();
    send(F1, c);
    expect_ev(c + 1, 1, 0, 0, 1, 8'h00, 8'h18, 8'd1);
    wait_cyc(TO - 1);
    send(F1, c);
    expect_ev(c + 1 + TO, 0, 1, 0, 0, 8'h00, 8'h18, 8'd1);
    wait_cyc(TO);
    send(F1, c);
    expect_ev(c + 1, 1, 0, 0, 1, 8'h00, 8'h18, 8'd2);
    wait_cyc(TO - 1);
    send(BAD1, c);
    expect_ev(c + 1, 0, 1, 1, 0, 8'h00, 8'h18, 8'd2);
    wait_cyc(5);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL expiry_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL expiry_event: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned c;
    logic [7:0] k, kn, n;
    ev_t e, o;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      k  = 8'(i);
      kn = ~k;
      n  = 8'(i + 1);
      send({8'h00, 8'hFF, k, kn}, c);
      expect_ev(c + 1, 1, (i != 0), 0, 1, 8'h00, k, n);
    end
    expect_ev(c + 1 + TO, 0, 1, 0, 0, 8'h00, 8'hFF, 8'd0);
    wait_cyc(TO + 5);
    vectors++;
    if (o_press_cnt !== 8'd0 || o_cmd !== 8'hFF) begin
      miscompares++;
      $display("FAIL wrap_cnt: got cnt=%0d cmd=%h want cnt=0 cmd=ff", o_press_cnt, o_cmd);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL b2b_event: got %h want %h", o, e); end
    end
  endtask

  task automatic test_async_reset();
    int unsigned c;
    ev_t e, o;
    do_reset();
    send(F1, c);
    expect_ev(c + 1, 1, 0, 0, 1, 8'h00, 8'h18, 8'd1);
    wait_cyc(10);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_addr, o_cmd, o_key_press, o_key_release, o_key_held, o_frame_err, o_press_cnt} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got addr=%h cmd=%h p=%b r=%b h=%b e=%b cnt=%h want all zero",
               o_addr, o_cmd, o_key_press, o_key_release, o_key_held, o_frame_err, o_press_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cyc(3);
    send(F1, c);
    expect_ev(c + 1, 1, 0, 0, 1, 8'h00, 8'h18, 8'd1);
    expect_ev(c + 1 + TO, 0, 1, 0, 0, 8'h00, 8'h18, 8'd1);
    wait_cyc(TO + 5);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL arst_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL arst_event: got %h want %h", o, e); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_press();
    test_hold();
    test_change();
    test_bad();
    test_expiry();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ir_key_ctrl.md
Name: ir_key_ctrl

Overview:
- Sits directly downstream of the IR receiver and consumes its 32-bit NEC frame (custom code plus data code) together with a one-cycle completion strobe.
- Checks frame integrity and converts the stream of frames into clean key events: press, hold and release.
- Key release is detected by a hold timeout.
- Outputs drive the display and control logic: latched address and command, event pulses, a held level and a press counter.

Parameters:
- TIMEOUT_CYC, 6000000: clk cycles without a matching frame before a held key is released (120 ms at 50 MHz).
- ADDR_CHECK, 1: 1 = require address byte == ~address-complement byte; 0 = extended-address mode, address pair not checked.
- CNT_W, 8: width of the press counter.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- i_frame  input  32  NEC frame: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
- i_frame_vld  input  1  one-cycle pulse; i_frame is stable and valid in that cycle.
- o_addr  output  8  address of the current or last accepted key.
- o_cmd  output  8  command of the current or last accepted key.
- o_key_press  output  1  one-cycle pulse on a new key press.
- o_key_release  output  1  one-cycle pulse on key release.
- o_key_held  output  1  high while a key is considered pressed.
- o_frame_err  output  1  one-cycle pulse on a frame that fails the integrity check.
- o_press_cnt  output  CNT_W  count of accepted presses; wraps.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; timer 0; o_addr=0, o_cmd=0, o_press_cnt=0; all pulses 0; o_key_held=0.
- A release of reset mid-hold restarts in IDLE with no pulses.
- Integrity check, evaluated only in a cycle with i_frame_vld=1:
  - ok = (i_frame[15:8] ^ i_frame[7:0]) == 8'hFF;
  - when ADDR_CHECK=1, ok additionally requires (i_frame[31:24] ^ i_frame[23:16]) == 8'hFF.
- Latency: every output responds one clk after the i_frame_vld cycle, or one clk after the timer expires. All outputs are registered.
- Bad frame: o_frame_err=1 for 1 cycle. State, timer, o_addr, o_cmd and o_press_cnt are unchanged. The timer is not reloaded.
- State machine: IDLE, HELD.
- IDLE + good frame:
  - go to HELD;
  - o_addr/o_cmd latch i_frame[31:24]/[15:8];
  - o_key_press pulse;
  - o_press_cnt+1 (all-ones wraps to 0);
  - timer cleared;
  - o_key_held=1 from that cycle.
- HELD + good frame with the same addr and cmd: hold refresh. Timer cleared; no pulses; counter unchanged.
- HELD + good frame with a different addr or cmd (key change):
  - o_key_release and o_key_press pulse in the same cycle;
  - o_addr/o_cmd update to the new code;
  - o_press_cnt+1; timer cleared;
  - o_key_held stays 1 with no low cycle.
- HELD, no good frame: timer increments each clk.
- Timer reaches TIMEOUT_CYC-1:
  - next cycle: o_key_release pulse, o_key_held=0, state IDLE, timer 0;
  - o_addr/o_cmd keep the last value.
- Simultaneous events:
  - A good frame in the expiry cycle wins. The hold is refreshed, or the key changes, and no timeout release is issued.
  - A bad frame in the expiry cycle: o_frame_err and the timeout release both pulse.
- The timer is a saturating-free counter of width ceil(log2(TIMEOUT_CYC)). It only runs in HELD and is held at 0 in IDLE.
- i_frame is ignored whenever i_frame_vld=0. Back-to-back i_frame_vld pulses on consecutive cycles are each processed.
- Constraint: TIMEOUT_CYC must be at least 2.

Test Plan (TIMEOUT_CYC=100 for sim):
- Reset then frame 32'h00FF_18E7 pulsed -> after 1 clk: o_key_press=1 for 1 cycle, o_addr=00, o_cmd=18, o_key_held=1, o_press_cnt=1; 100 clks later o_key_release=1 for 1 cycle, o_key_held=0, o_cmd stays 18.
- Same frame 32'h00FF_18E7 repeated every 60 clks, 5 times -> exactly one press, no release until 100 clks after the last frame; o_press_cnt=1.
- Frame 32'h00FF_18E7, then 32'h00FF_5AA5 30 clks later -> press and release pulses in the same cycle, o_cmd=5A, o_key_held never drops, o_press_cnt=2.
- Bad frames 32'h00FF_1818 and 32'h01FF_18E7 (ADDR_CHECK=1) -> o_frame_err pulses, no press, o_press_cnt unchanged. With ADDR_CHECK=0 the second frame is accepted with o_addr=01.
- Good frame arriving exactly on timer expiry -> no release, hold refreshed. Separately, 256 distinct-key presses -> o_press_cnt wraps to 0.
- Assert rst_n low mid-HELD -> all outputs 0 immediately (asynchronous). After release, a same-code frame gives a fresh press pulse.
